// File: rtl/mcs4_timing_pkg.sv
// mcs4_timing: shared MCS-4 phase indices, phase width and sysclk-per-cycle constant.
package mcs4_timing;
  localparam int PH_A1 = 0;
  localparam int PH_A2 = 1;
  localparam int PH_A3 = 2;
  localparam int PH_M1 = 3;
  localparam int PH_M2 = 4;
  localparam int PH_X1 = 5;
  localparam int PH_X2 = 6;
  localparam int PH_X3 = 7;
  localparam int PH_N = 8;
  localparam int SYSCLK_PER_CYC = 20;
  typedef logic [PH_N-1:0] ph_t;
endpackage

// File: rtl/phase_recovery_edge_detect.sv
// edge_detect: registered copy of a level input with rise/fall pulses; reset level chosen by port.
module edge_detect (
  input  logic sysclk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic level_q, level_d;
  always_comb level_d = din;
  always_ff @(posedge sysclk)
    if (!rst_n) level_q <= rst_val;
    else level_q <= level_d;
  assign level = level_q;
  assign rise = din & ~level_q;
  assign fall = ~din & level_q;
endmodule

// File: rtl/phase_recovery.sv
// phase_recovery: regenerates MCS-4 one-hot execution phases from clk1/clk2/sync, with lock and sync error.
// Optional saturating err_count port enabled by PHASE_RECOVERY_ERRCNT_EN.
module phase_recovery
  import mcs4_timing::*;
(
  input  logic sysclk,
  input  logic rst_n,
  input  logic clk1,
  input  logic clk2,
  input  logic sync,
  output logic a12,
  output logic a22,
  output logic a32,
  output logic m12,
  output logic m22,
  output logic x12,
  output logic x22,
  output logic x32,
  output logic locked,
  output logic sync_err
`ifdef PHASE_RECOVERY_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);
  logic clk1_rise, clk1_fall, clk1_lvl, clk2_rise, clk2_fall, clk2_lvl;
  logic unused_edges;
  // Reset the registered levels high so a clock held high through reset gives no false rise.
  edge_detect u_clk1 (
    .sysclk(sysclk), .rst_n(rst_n), .rst_val(1'b1), .din(clk1),
    .level(clk1_lvl), .rise(clk1_rise), .fall(clk1_fall)
  );
  edge_detect u_clk2 (
    .sysclk(sysclk), .rst_n(rst_n), .rst_val(1'b1), .din(clk2),
    .level(clk2_lvl), .rise(clk2_rise), .fall(clk2_fall)
  );
  assign unused_edges = ^{clk1_lvl, clk1_fall, clk2_lvl, clk2_rise};
  ph_t ph_q, ph_d;
  logic locked_q, locked_d, sync_err_q, sync_err_d, sync_lat_q, sync_lat_d;
  logic sync_now, idle, at_x3;
  always_comb begin
    sync_now = clk2_fall ? sync : sync_lat_q;
    sync_lat_d = clk1_rise ? 1'b0 : sync_now;
    idle = ~|ph_q;
    at_x3 = ph_q[PH_X3];
    ph_d = ph_q;
    locked_d = locked_q;
    sync_err_d = 1'b0;
    if (clk1_rise) begin
      if (sync_now) begin
        ph_d = ph_t'(1) << PH_A1;
        locked_d = idle | at_x3;
        sync_err_d = ~(idle | at_x3);
      end else if (at_x3) begin
        ph_d = '0;
        locked_d = 1'b0;
        sync_err_d = 1'b1;
      end else begin
        ph_d = {ph_q[PH_N-2:0], 1'b0};
      end
    end
  end
  always_ff @(posedge sysclk)
    if (!rst_n) begin
      ph_q <= '0;
      locked_q <= 1'b0;
      sync_err_q <= 1'b0;
      sync_lat_q <= 1'b0;
    end else begin
      ph_q <= ph_d;
      locked_q <= locked_d;
      sync_err_q <= sync_err_d;
      sync_lat_q <= sync_lat_d;
    end
`ifdef PHASE_RECOVERY_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;
  always_comb err_count_d = (sync_err_d && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
  always_ff @(posedge sysclk)
    if (!rst_n) err_count_q <= '0;
    else err_count_q <= err_count_d;
  assign err_count = err_count_q;
`endif
  assign a12 = ph_q[PH_A1];
  assign a22 = ph_q[PH_A2];
  assign a32 = ph_q[PH_A3];
  assign m12 = ph_q[PH_M1];
  assign m22 = ph_q[PH_M2];
  assign x12 = ph_q[PH_X1];
  assign x22 = ph_q[PH_X2];
  assign x32 = ph_q[PH_X3];
  assign locked = locked_q;
  assign sync_err = sync_err_q;
endmodule

// File: tb/tb_phase_recovery.sv
// tb_phase_recovery: randomized clk1/clk2/sync stimulus against a phase-index reference model via a scoreboard queue.
module tb_phase_recovery;
  import mcs4_timing::*;
  logic sysclk = 1'b0;
  logic rst_n = 1'b0, clk1 = 1'b0, clk2 = 1'b0, sync = 1'b0;
  logic a12, a22, a32, m12, m22, x12, x22, x32, locked, sync_err;
`ifdef PHASE_RECOVERY_ERRCNT_EN
  logic [7:0] err_count;
`endif
  always #5 sysclk = ~sysclk;

  phase_recovery dut (
    .sysclk(sysclk), .rst_n(rst_n), .clk1(clk1), .clk2(clk2), .sync(sync),
    .a12(a12), .a22(a22), .a32(a32), .m12(m12), .m22(m22),
    .x12(x12), .x22(x22), .x32(x32), .locked(locked), .sync_err(sync_err)
`ifdef PHASE_RECOVERY_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  typedef struct {
    logic [7:0] ph;
    logic lk;
    logic er;
    logic [7:0] cnt;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  // Reference model: phase as an integer index (-1 = idle), sync seen since last clk1 rise.
  int idx = -1, cnt = 0;
  bit lk = 0, lat = 0, p1 = 1, p2 = 1;

  task automatic tick(input logic c1, input logic c2, input logic s, input logic r);
    bit rise, fall, seen, err;
    exp_t e;
    @(negedge sysclk);
    clk1 = c1; clk2 = c2; sync = s; rst_n = r;
    err = 0;
    if (!r) begin
      idx = -1; lk = 0; lat = 0; p1 = 1; p2 = 1; cnt = 0;
    end else begin
      rise = c1 && !p1;
      fall = !c2 && p2;
      p1 = c1; p2 = c2;
      seen = fall ? s : lat;
      if (rise) begin
        if (seen) begin
          err = !(idx < 0 || idx == 7);
          lk = !err;
          idx = 0;
        end else if (idx == 7) begin
          idx = -1; lk = 0; err = 1;
        end else if (idx >= 0) idx++;
        if (err && cnt < 255) cnt++;
        lat = 0;
      end else lat = seen;
    end
    e.ph = (idx < 0) ? 8'h00 : 8'h01 << idx;
    e.lk = lk;
    e.er = err;
    e.cnt = 8'(cnt);
    sb.push_back(e);
  endtask

  // One instruction-phase period; mode 0 = normal sync, 1 = sync withheld, 2 = sync forced.
  task automatic period(input int mode, input int rst_at);
    logic s;
    for (int c = 0; c < SYSCLK_PER_CYC; c++) begin
      s = (c == 0) ? 1'b0 : (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : (idx == 7 || idx < 0);
      tick(c < 5, c >= 10 && c < 15, s, c != rst_at);
    end
  endtask

  task automatic to_phase(input int t);
    for (int i = 0; i < 20 && idx != t; i++) period(0, -1);
  endtask

  exp_t em;
  logic [7:0] act_ph;
  initial forever begin
    @(posedge sysclk);
    #1;
    if (sb.size() != 0) begin
      em = sb.pop_front();
      act_ph = {x32, x22, x12, m22, m12, a32, a22, a12};
      checks++;
      if (act_ph !== em.ph || locked !== em.lk || sync_err !== em.er) begin
        errors++;
        $display("FAIL phase_out t=%0t got ph=%b locked=%b sync_err=%b, required ph=%b locked=%b sync_err=%b",
                 $time, act_ph, locked, sync_err, em.ph, em.lk, em.er);
      end
`ifdef PHASE_RECOVERY_ERRCNT_EN
      checks++;
      if (err_count !== em.cnt) begin
        errors++;
        $display("FAIL err_count t=%0t got %0d, required %0d", $time, err_count, em.cnt);
      end
`endif
    end
  end

  initial begin
    for (int c = 0; c < 23; c++)
      tick((c % SYSCLK_PER_CYC) < 5, (c % SYSCLK_PER_CYC) >= 10 && (c % SYSCLK_PER_CYC) < 15, 1'b0, 1'b0);
    repeat (30) period(0, -1);
    to_phase(7);
    period(1, -1);
    repeat (12) period(0, -1);
    to_phase(3);
    period(2, -1);
    repeat (12) period(0, -1);
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) tick(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) tick(1'b0, 1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (4) tick(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (5) tick(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) tick(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (5) tick(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (10) period(0, -1);
    to_phase(4);
    period(0, 7);
    repeat (12) period(0, -1);
    for (int i = 0; i < 150; i++) begin
      int m;
      m = $urandom_range(0, 9);
      period(m == 0 ? 1 : m == 1 ? 2 : 0, ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 19)) : -1);
    end
`ifdef PHASE_RECOVERY_ERRCNT_EN
    for (int i = 0; i < 300; i++) begin
      to_phase(7);
      period(1, -1);
    end
    repeat (3) period(0, -1);
`endif
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge sysclk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
